// File: rtl/free_list_pkg.sv
// Shared sizing constants and the retire-to-free-list packet for the 3-way pipeline.
package free_list_pkg;

  localparam int unsigned PR_DEFAULT      = 6;
  localparam int unsigned FL_SIZE_DEFAULT = (1 << PR_DEFAULT) - 32;
  localparam int unsigned WAYS_DEFAULT    = 3;

  // One retiring ROB entry as seen by the free list.
  typedef struct packed {
    logic                  valid;
    logic [PR_DEFAULT-1:0] told;
  } free_list_retire_t;

endpackage

// File: rtl/free_list_retire_compact.sv
// Prefix-popcount of retire valids: per-way write offset into the tail and the total freed.
module free_list_retire_compact #(
  parameter int unsigned WAYS = 3,
  parameter int unsigned CW   = $clog2(WAYS + 1)
) (
  input  logic [WAYS-1:0]         valid,
  output logic [WAYS-1:0][CW-1:0] offset,
  output logic [CW-1:0]           num
);

  always_comb begin
    num = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      offset[w] = num;
      num       = num + CW'(valid[w]);
    end
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular tag buffer with speculative and architectural heads.
module free_list
  import free_list_pkg::*;
#(
  parameter int unsigned PR      = PR_DEFAULT,
  parameter int unsigned FL_SIZE = FL_SIZE_DEFAULT,
  parameter int unsigned WAYS    = WAYS_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    dispatch_num,
  input  logic [WAYS-1:0]               retire_valid,
  input  logic [WAYS-1:0][PR-1:0]       retire_told,
  input  logic                          squash,
  output logic [WAYS-1:0][PR-1:0]       free_pr,
  output logic [$clog2(FL_SIZE+1)-1:0]  free_count,
  output logic [WAYS-1:0]               struct_stall
);

  // FL_SIZE must be a power of two so pointer arithmetic wraps naturally.
  localparam int unsigned PW   = $clog2(FL_SIZE);
  localparam int unsigned CNTW = $clog2(FL_SIZE + 1);
  localparam int unsigned CW   = $clog2(WAYS + 1);

  logic [PR-1:0]   storage_q [FL_SIZE];
  logic [PW-1:0]   spec_head_q, spec_head_d;
  logic [PW-1:0]   arch_head_q, arch_head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;

  logic [1:0]                 disp_eff;
  logic [WAYS-1:0][CW-1:0]    wr_off;
  logic [CW-1:0]              ret_num;
  logic [PW-1:0]              wr_idx [WAYS];

  free_list_retire_compact #(
    .WAYS (WAYS),
    .CW   (CW)
  ) u_compact (
    .valid  (retire_valid),
    .offset (wr_off),
    .num    (ret_num)
  );

  always_comb begin
    disp_eff = dispatch_num;
    if (CNTW'(dispatch_num) > count_q) begin
      disp_eff = count_q[1:0];
    end

    for (int unsigned w = 0; w < WAYS; w++) begin
      wr_idx[w] = tail_q + PW'(wr_off[w]);
    end

    tail_d      = tail_q + PW'(ret_num);
    arch_head_d = arch_head_q + PW'(ret_num);
    if (squash) begin
      // Recover to post-retire architectural state; in-flight slots were never overwritten.
      spec_head_d = arch_head_d;
      count_d     = CNTW'(FL_SIZE);
    end else begin
      spec_head_d = spec_head_q + PW'(disp_eff);
      count_d     = count_q + CNTW'(ret_num) - CNTW'(disp_eff);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      count_q     <= CNTW'(FL_SIZE);
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        storage_q[i] <= PR'((2 ** PR) - FL_SIZE + i);
      end
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (retire_valid[w]) begin
          storage_q[wr_idx[w]] <= retire_told[w];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      free_pr[w]      = storage_q[spec_head_q + PW'(w)];
      struct_stall[w] = (count_q <= CNTW'(w));
    end
    free_count = count_q;
  end

  always_ff @(posedge clock) begin
    if (!reset && !squash) begin
      assert (CNTW'(dispatch_num) <= count_q)
        else $warning("free_list: dispatch_num %0d exceeds free count %0d, clamped",
                      dispatch_num, count_q);
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, clamp, retire compaction, wrap, squash, async reset.
module tb_free_list;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      dispatch_num;
  logic [2:0]      retire_valid;
  logic [2:0][5:0] retire_told;
  logic            squash;
  logic [2:0][5:0] free_pr;
  logic [5:0]      free_count;
  logic [2:0]      struct_stall;

  int n_vec  = 0;
  int n_miss = 0;
  int fifo[$];
  int mc;
  int nt;
  int eff;

  always #5 clock = ~clock;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_num (dispatch_num),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .squash       (squash),
    .free_pr      (free_pr),
    .free_count   (free_count),
    .struct_stall (struct_stall)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_num = 2'd0;
    retire_valid = 3'b000;
    retire_told  = '0;
    squash       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_way0"},  int'(free_pr[0]),   32);
    check({tag, "_way1"},  int'(free_pr[1]),   33);
    check({tag, "_way2"},  int'(free_pr[2]),   34);
    check({tag, "_count"}, int'(free_count),   32);
    check({tag, "_stall"}, int'(struct_stall), 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset_outputs("rst");

    // Drain with dispatch 3; final request is clamped from 3 to 2
    mc = 32;
    nt = 32;
    for (int k = 0; k < 11; k++) begin
      check("drain_way0", int'(free_pr[0]), nt);
      if (k == 10) check("drain_last_way1", int'(free_pr[1]), 63);
      dispatch_num = 2'd3;
      tick();
      eff = (mc < 3) ? mc : 3;
      mc -= eff;
      nt += eff;
      check("drain_count", int'(free_count), mc);
    end
    idle();
    check("empty_count", int'(free_count), 0);
    check("empty_stall", int'(struct_stall), 7);

    // Non-contiguous retire from empty
    retire_valid   = 3'b101;
    retire_told[0] = 6'd3;
    retire_told[1] = 6'd9;
    retire_told[2] = 6'd7;
    tick();
    idle();
    check("r101_count", int'(free_count), 2);
    check("r101_way0",  int'(free_pr[0]), 3);
    check("r101_way1",  int'(free_pr[1]), 7);
    check("r101_stall", int'(struct_stall), 4);

    dispatch_num = 2'd2;
    tick();
    idle();
    check("reempty_count", int'(free_count), 0);

    // Empty, retire 3 with no dispatch
    retire_valid   = 3'b111;
    retire_told[0] = 6'd20;
    retire_told[1] = 6'd21;
    retire_told[2] = 6'd22;
    tick();
    idle();
    check("r111_count", int'(free_count), 3);
    check("r111_way0",  int'(free_pr[0]), 20);
    check("r111_way1",  int'(free_pr[1]), 21);
    check("r111_way2",  int'(free_pr[2]), 22);
    check("r111_stall", int'(struct_stall), 0);

    // Steady state dispatch 3 / retire 3 with wrap
    do_reset();
    fifo.delete();
    for (int i = 0; i < 32; i++) fifo.push_back(32 + i);
    for (int c = 0; c < 40; c++) begin
      check("steady_way0", int'(free_pr[0]), fifo[0]);
      check("steady_way1", int'(free_pr[1]), fifo[1]);
      check("steady_way2", int'(free_pr[2]), fifo[2]);
      dispatch_num = 2'd3;
      retire_valid = 3'b111;
      for (int w = 0; w < 3; w++) retire_told[w] = 6'((3 * c + w) % 32);
      tick();
      for (int w = 0; w < 3; w++) void'(fifo.pop_front());
      for (int w = 0; w < 3; w++) fifo.push_back((3 * c + w) % 32);
      check("steady_count", int'(free_count), 32);
    end
    idle();

    // Allocate 5, then squash with a same-cycle retire of 2
    do_reset();
    dispatch_num = 2'd3;
    tick();
    dispatch_num = 2'd2;
    tick();
    idle();
    check("alloc5_count", int'(free_count), 27);
    check("alloc5_way0",  int'(free_pr[0]), 37);
    retire_valid   = 3'b011;
    retire_told[0] = 6'd10;
    retire_told[1] = 6'd11;
    squash         = 1'b1;
    dispatch_num   = 2'd3;
    tick();
    idle();
    check("squash_count", int'(free_count), 32);
    check("squash_way0",  int'(free_pr[0]), 34);
    check("squash_way1",  int'(free_pr[1]), 35);
    check("squash_way2",  int'(free_pr[2]), 36);

    // Asynchronous reset while count is 10
    do_reset();
    for (int k = 0; k < 7; k++) begin
      dispatch_num = 2'd3;
      tick();
    end
    dispatch_num = 2'd1;
    tick();
    idle();
    check("pre_async_count", int'(free_count), 10);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    reset = 1'b0;
    tick();
    check("post_async_count", int'(free_count), 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the 3-way dispatch/retire pipeline. Hands out up to three free physical register tags per cycle to dispatch, where they become the ROB entry `Tnew` fields. Reclaims the `Told` tags of retired ROB entries. On squash, rolls speculative allocations back so the free list matches retirement state.

## Interface
- `PR`: default 6. Physical tag width (64 physical registers), taken from the shared `PR` macro.
- `FL_SIZE`: default 32. Number of non-architectural physical registers. Equals 2^`PR` − 32.
- `WAYS`: default 3. Dispatch and retire width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dispatch_num` in 2: number of tags consumed this cycle (0–3). Dispatch takes them from way 0 upward.
- `retire_valid` in 3: per-way flag; way i retires an entry that frees its `Told`. Way 0 is the oldest. Set bits may be non-contiguous.
- `retire_told` in 3×`PR`: tags being freed, one per way.
- `squash` in 1: mispredict/exception recovery request.
- `free_pr` out 3×`PR`: the next three free tags in FIFO order. Way 0 is the oldest.
- `free_count` out 6: number of free tags, 0–32.
- `struct_stall` out 3: bit i set when free_count ≤ i. Same encoding as the ROB `struct_stall`.

## Operation
- Storage is a circular buffer of `FL_SIZE` tags with three 5-bit pointers:
  - `spec_head`: next tag to allocate.
  - `arch_head`: oldest tag not yet committed to a retired instruction.
  - `tail`: next write slot.
- Plus a registered 6-bit `count` (free tags), used to tell full from empty.
- Reset values:
  - slot i holds 32+i;
  - spec_head = arch_head = tail = 0;
  - count = 32;
  - free_pr = {34, 33, 32} (way 2..0);
  - struct_stall = 3'b000.
- Allocate: spec_head advances by dispatch_num, mod 32.
  - If dispatch_num exceeds count, that is an illegal request: it is flagged by an assertion and clamped to count.
- Retire:
  - r = popcount(retire_valid).
  - Valid `Told`s are compacted in way order and written to tail, tail+1, …; tail advances by r.
  - arch_head advances by r, since each retired entry had allocated exactly one tag.
- count_next = count + r − dispatch_num, arithmetic in 6 bits. The result is always in 0..32.
- Squash:
  - spec_head_next = arch_head + r (the retire of the same cycle is included).
  - count_next = 32.
  - dispatch_num is ignored that cycle.
  - Storage between arch_head and spec_head is never overwritten before retirement, so these tags are restored intact.
- Invariant: tail − arch_head ≡ 0 (mod 32) with 32 tags live, whether free or in flight. Storage never overflows.
- free_pr[i] = storage[spec_head + i], mod 32. Only ways below count are meaningful.

## Timing
- free_pr, free_count and struct_stall are combinational from registered state only. No input→output combinational path.
- A tag allocated in cycle N no longer appears at free_pr way 0 from cycle N+1.
- A tag freed in cycle N is allocatable from cycle N+1. There is no same-cycle bypass.
- When count = 0 and retire frees 3 while dispatch_num = 0, count = 3 in the next cycle.
- Pointers wrap from 31 to 0 without a gap.
- Squash together with retire: retire writes happen, and spec_head is set to the post-retire arch_head.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

## Structure
- `PR`, `FL_SIZE` and the 3-way width macro live in the shared sysdefs header next to `ROB`/`ROBW`.
- A `FREE_LIST_RETIRE` packet (valid, Told) typedef goes in the shared package so the retire stage can drive it from ROB retire entries.
- One natural sub-module, `retire_compact`: a 3-way valid-compaction and prefix-popcount unit producing write offsets and r.

## Test plan
- Reset:
  - free_pr = {34, 33, 32};
  - free_count = 32;
  - struct_stall = 000.
- dispatch_num = 3 for 11 cycles with no retire:
  - count goes 29, 26, … down to 0 after 10 cycles with dispatch 3, then a clamped dispatch of 2;
  - struct_stall = 111 at count 0;
  - the final allocation is tags 62 and 63;
  - the clamp assertion fires on the illegal request.
- From the empty state, retire_valid = 101 with Told = {7, x, 3}:
  - next cycle count = 2, free_pr way 0 = 3, way 1 = 7.
- Dispatch 3 and retire 3 every cycle for 40 cycles:
  - count stays 32;
  - pointers wrap past 31;
  - free_pr order follows the retired Told order.
- Allocate 5 tags (32–36), retire 2 in the same cycle as squash:
  - next cycle count = 32;
  - free_pr way 0 = 34, then 35 and 36 follow.
- Assert reset while count = 10:
  - all outputs return to reset values before the next clock edge.
